// File: rtl/blk_pkg.sv
// Shared screen geometry, colour/address widths, FSM state type and the
// framebuffer pixel-address helper for block_reader.
package blk_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // py*160 + px built from two shifts so no multiplier is needed
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] px,
                                                 input logic [6:0] py);
    logic [ADDR_W-1:0] row;
    row = ADDR_W'(py);
    return (row << 7) + (row << 5) + ADDR_W'(px);
  endfunction

endpackage

// File: rtl/block_reader_rd_tag_pipe.sv
// rd_tag_pipe: valid-tag shift register matching the framebuffer read latency,
// so returning data is only used for reads this scan actually issued.
module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic rd_en,
  output logic tag_out
);

  logic [DEPTH-1:0] tag_q, tag_d;

  always_comb begin
    tag_d    = '0;
    tag_d[0] = rd_en;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Flushing on reset drops data still in flight from an aborted scan
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_out = tag_q[DEPTH-1];

endmodule

// File: rtl/block_reader.sv
// block_reader: scans a BLOCK_W x BLOCK_H pixel block of the framebuffer and
// reports whether any pixel differs from BG_COLOUR. Macro BLOCK_READER_COUNT_EN
// additionally builds a saturating occupied-pixel counter on occ_count.
module block_reader
  import blk_pkg::*;
#(
  parameter int                  BLOCK_W    = 4,
  parameter int                  BLOCK_H    = 4,
  parameter int                  RD_LATENCY = 1,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = 3'b000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  output logic                busy,
  output logic                done,
  output logic                occupied,
  output logic [4:0]          occ_count,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [COLOUR_W-1:0] mem_rd_data
);

  localparam int CW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int RW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(BLOCK_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(BLOCK_H - 1);
  localparam logic [2:0]    DRAIN_INIT = 3'(RD_LATENCY - 1);

  state_t        state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0]    drain_q, drain_d;
  logic          occupied_q, occupied_d;

  logic [8:0] px;
  logic [7:0] py;
  logic       in_screen;
  logic       tag_out;
  logic       hit;

  // Coordinates carry one extra bit so blocks hanging off the edge never wrap
  assign px        = {1'b0, x_q} + 9'(col_q);
  assign py        = {1'b0, y_q} + 8'(row_q);
  assign in_screen = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));

  assign mem_rd_en = (state_q == ST_READ) && in_screen;
  assign mem_addr  = mem_rd_en ? pix_addr(px[7:0], py[6:0]) : '0;

  rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .resetn (resetn),
    .rd_en  (mem_rd_en),
    .tag_out(tag_out)
  );

  assign hit = tag_out && (mem_rd_data != BG_COLOUR);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    col_d      = col_q;
    row_d      = row_q;
    drain_d    = drain_q;
    occupied_d = occupied_q | hit;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d        = x;
          y_d        = y;
          col_d      = '0;
          row_d      = '0;
          occupied_d = 1'b0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            drain_d = DRAIN_INIT;
            state_d = ST_DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      drain_q    <= '0;
      occupied_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      col_q      <= col_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
      occupied_q <= occupied_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign occupied = occupied_q;

`ifdef BLOCK_READER_COUNT_EN
  logic [4:0] occ_count_q, occ_count_d;

  always_comb begin
    occ_count_d = occ_count_q;
    if ((state_q == ST_IDLE) && start) begin
      occ_count_d = '0;
    end else if (hit && (occ_count_q != 5'd31)) begin
      occ_count_d = occ_count_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      occ_count_q <= '0;
    end else begin
      occ_count_q <= occ_count_d;
    end
  end

  assign occ_count = occ_count_q;
`else
  assign occ_count = 5'd0;
`endif

endmodule

// File: tb/tb_block_reader.sv
// Scoreboard bench for block_reader: two instances (read latency 1 and 3)
// share stimulus; a reference model predicts read addresses and results.
module tb_block_reader;

  typedef struct {
    int t_done;
    bit occ;
    int cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;

  logic        busy_w  [2];
  logic        done_w  [2];
  logic        occ_w   [2];
  logic [4:0]  cnt_w   [2];
  logic        rden_w  [2];
  logic [14:0] addr_w  [2];
  logic [2:0]  rdata_w [2];

  logic [2:0]  mem [0:19199];
  logic [14:0] apipe [2][4];
  logic        vpipe [2][4];

  exp_t sb [2][$];
  int   aq [2][$];
  bit   act [2];
  int   t0 [2];
  int   tdone [2];
  bit   last_occ [2];
  int   last_cnt [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  block_reader #(.BLOCK_W(4), .BLOCK_H(4), .RD_LATENCY(1), .BG_COLOUR(3'b000)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y),
    .busy(busy_w[0]), .done(done_w[0]), .occupied(occ_w[0]), .occ_count(cnt_w[0]),
    .mem_rd_en(rden_w[0]), .mem_addr(addr_w[0]), .mem_rd_data(rdata_w[0]));

  block_reader #(.BLOCK_W(4), .BLOCK_H(4), .RD_LATENCY(3), .BG_COLOUR(3'b000)) u_dut3 (
    .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y),
    .busy(busy_w[1]), .done(done_w[1]), .occupied(occ_w[1]), .occ_count(cnt_w[1]),
    .mem_rd_en(rden_w[1]), .mem_addr(addr_w[1]), .mem_rd_data(rdata_w[1]));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer models: data returns lat(i) cycles after the read; junk otherwise
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 3; k > 0; k--) begin
        apipe[i][k] <= apipe[i][k-1];
        vpipe[i][k] <= vpipe[i][k-1];
      end
      apipe[i][0] <= addr_w[i];
      vpipe[i][0] <= rden_w[i];
    end
  end
  assign rdata_w[0] = vpipe[0][0] ? mem[apipe[0][0]] : 3'b111;
  assign rdata_w[1] = vpipe[1][2] ? mem[apipe[1][2]] : 3'b111;

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops expected reads and results as the DUTs present them
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      for (int i = 0; i < 2; i++) begin
        if (rden_w[i]) begin
          if (aq[i].size() == 0) chk($sformatf("unexpected_read%0d", i), 1, 0);
          else chk($sformatf("rd_addr%0d", i), int'(addr_w[i]), aq[i].pop_front());
        end else begin
          chk($sformatf("idle_addr%0d", i), int'(addr_w[i]), 0);
        end
        chk($sformatf("busy%0d", i), int'(busy_w[i]),
            int'(act[i] && cyc > t0[i] && cyc <= tdone[i]));
        chk($sformatf("done%0d", i), int'(done_w[i]), int'(act[i] && cyc == tdone[i]));
        if (done_w[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("unexpected_done%0d", i), 1, 0);
          end else begin
            e = sb[i].pop_front();
            chk($sformatf("done_cycle%0d", i), cyc - t0[i], e.t_done - t0[i]);
            chk($sformatf("occupied%0d", i), int'(occ_w[i]), int'(e.occ));
            chk($sformatf("occ_count%0d", i), int'(cnt_w[i]), e.cnt);
            chk($sformatf("reads_left%0d", i), aq[i].size(), 0);
            last_occ[i] = e.occ;
            last_cnt[i] = e.cnt;
          end
        end else if (act[i] && cyc > tdone[i]) begin
          chk($sformatf("hold_occ%0d", i), int'(occ_w[i]), int'(last_occ[i]));
          chk($sformatf("hold_cnt%0d", i), int'(cnt_w[i]), last_cnt[i]);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), int'(busy_w[i]), 0);
      chk($sformatf("%s_done%0d", tag, i), int'(done_w[i]), 0);
      chk($sformatf("%s_occ%0d", tag, i), int'(occ_w[i]), 0);
      chk($sformatf("%s_cnt%0d", tag, i), int'(cnt_w[i]), 0);
      chk($sformatf("%s_rden%0d", tag, i), int'(rden_w[i]), 0);
      chk($sformatf("%s_addr%0d", tag, i), int'(addr_w[i]), 0);
    end
  endtask

  task automatic fill(input int mode);
    for (int a = 0; a < 19200; a++) begin
      case (mode)
        0: mem[a] = 3'd0;
        1: mem[a] = 3'd7;
        2: mem[a] = 3'd2;
        default: mem[a] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      endcase
    end
  endtask

  // Called #1 after a negedge with both DUTs idle; this cycle is cycle 0
  task automatic launch(input int xs, input int ys);
    int   cnt;
    int   addrs[$];
    exp_t e;
    cnt = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (xs + c < 160 && ys + r < 120) begin
          addrs.push_back((ys + r) * 160 + xs + c);
          if (mem[(ys + r) * 160 + xs + c] != 3'd0) cnt++;
        end
      end
    end
    start = 1'b1;
    x = 8'(xs);
    y = 7'(ys);
    for (int i = 0; i < 2; i++) begin
      t0[i]    = cyc;
      tdone[i] = cyc + 16 + lat(i) + 1;
      act[i]   = 1'b1;
      foreach (addrs[k]) aq[i].push_back(addrs[k]);
      e.t_done = tdone[i];
      e.occ    = (cnt > 0);
`ifdef BLOCK_READER_COUNT_EN
      e.cnt = (cnt > 31) ? 31 : cnt;
`else
      e.cnt = 0;
`endif
      sb[i].push_back(e);
    end
    @(negedge clk);
    #1;
    start = 1'b0;
    x = 8'($urandom_range(0, 255));
    y = 7'($urandom_range(0, 127));
  endtask

  task automatic wait_done();
    while (cyc < tdone[1] + 3) @(negedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int k);
    while (cyc < t0[0] + k) @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        apipe[i][k] = '0;
        vpipe[i][k] = 1'b0;
      end
    end
    fill(0);
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    #1;

    // Empty block
    launch(10, 20);
    wait_done();

    // Single occupied pixel
    mem[3371] = 3'b100;
    launch(10, 20);
    wait_done();

    // Clipping at the bottom-right corner
    fill(3);
    launch(158, 118);
    wait_done();

    // Starts during READ and DONE are ignored
    launch(30, 40);
    wait_cycle(5);
    start = 1'b1;
    x = 8'd0;
    y = 7'd0;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_cycle(18);
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset mid-scan, then an immediate new scan
    fill(1);
    launch(10, 20);
    wait_cycle(9);
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      sb[i].delete();
      aq[i].delete();
    end
    @(negedge clk);
    #1;
    check_zero("midreset");
    resetn = 1'b1;
    launch(10, 20);
    wait_done();

    // Full block of a non-background colour
    fill(2);
    launch(40, 50);
    wait_done();

    // Randomized scans, including edge-hugging positions
    for (int n = 0; n < 20; n++) begin
      fill(3);
      if (n % 4 == 0) launch($urandom_range(155, 159), $urandom_range(115, 119));
      else launch($urandom_range(0, 159), $urandom_range(0, 119));
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
